// File: rtl/mux41_pkg.sv
// Shared select type, select encodings and one-hot decode helper for the 4:1 selector.
package mux41_pkg;

    localparam int unsigned SEL_W = 2;
    localparam int unsigned OH_W  = 4;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_I0 = 2'b00;
    localparam sel_t SEL_I1 = 2'b01;
    localparam sel_t SEL_I2 = 2'b10;
    localparam sel_t SEL_I3 = 2'b11;

    // One-hot decode: bit n high when source In is selected.
    function automatic logic [OH_W-1:0] sel_onehot(input sel_t s);
        logic [OH_W-1:0] oh;
        oh = '0;
        case (s)
            SEL_I0:  oh = 4'b0001;
            SEL_I1:  oh = 4'b0010;
            SEL_I2:  oh = 4'b0100;
            default: oh = 4'b1000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mux41_comb.sv
// Combinational WIDTH-wide 4:1 selector.
//   i0..i3 : data sources
//   sel    : source index (00 -> i0 ... 11 -> i3)
//   y      : selected data, zero latency
module mux41_comb
    import mux41_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  sel_t             sel,
    output logic [WIDTH-1:0] y
);

    // Full case: the default arm covers SEL_I3 so no latch can be inferred.
    always_comb begin
        y = '0;
        case (sel)
            SEL_I0:  y = i0;
            SEL_I1:  y = i1;
            SEL_I2:  y = i2;
            default: y = i3;
        endcase
    end

endmodule

// File: rtl/mux41_bh.sv
// 4:1 selector with combinational output, registered copy with valid flag,
// one-hot select decode and select-change tracking.
//   clk, rst_n       : clock, asynchronous active-low reset
//   I0..I3           : WIDTH-bit data sources
//   S1, S0           : select MSB / LSB
//   en               : capture enable for Y_q
//   Y                : combinational selected data
//   Y_q, Y_vld       : registered selected data, loaded-last-edge flag
//   sel_oh           : combinational one-hot decode of {S1,S0}
//   sel_chg, chg_cnt : registered select-change pulse, saturating change count
module mux41_bh
    import mux41_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic             S0,
    input  logic             S1,
    input  logic             en,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
    output logic             Y_vld,
    output logic [OH_W-1:0]  sel_oh,
    output logic             sel_chg,
    output logic [CNT_W-1:0] chg_cnt
);

    sel_t sel;
    sel_t sel_prev;
    logic sel_diff_c;

    assign sel        = {S1, S0};
    assign sel_oh     = sel_onehot(sel);
    assign sel_diff_c = (sel != sel_prev);

    mux41_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .i0  (I0),
        .i1  (I1),
        .i2  (I2),
        .i3  (I3),
        .sel (sel),
        .y   (Y)
    );

    // Registered copy of Y; valid only on edges where en was sampled high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y_q   <= '0;
            Y_vld <= 1'b0;
        end else begin
            Y_vld <= en;
            if (en) begin
                Y_q <= Y;
            end
        end
    end

    // Edge-sampled select change detection with saturating counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_prev <= SEL_I0;
            sel_chg  <= 1'b0;
            chg_cnt  <= '0;
        end else begin
            sel_prev <= sel;
            sel_chg  <= sel_diff_c;
            if (sel_diff_c && (chg_cnt != {CNT_W{1'b1}})) begin
                chg_cnt <= chg_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux41_bh.sv
// Directed self-checking bench for mux41_bh: an 8-bit instance (a) with the
// default counter and a 1-bit instance (b) with a 2-bit counter share clock,
// reset, select and enable.
module tb_mux41_bh;

    logic       clk;
    logic       rst_n;
    logic       S0, S1, en;

    logic [7:0] a_i0, a_i1, a_i2, a_i3;
    logic [7:0] a_y, a_yq;
    logic       a_vld, a_chg;
    logic [3:0] a_oh;
    logic [7:0] a_cnt;

    logic [0:0] b_i0, b_i1, b_i2, b_i3;
    logic [0:0] b_y, b_yq;
    logic       b_vld, b_chg;
    logic [3:0] b_oh;
    logic [1:0] b_cnt;

    int n_total;
    int n_fail;

    mux41_bh #(.WIDTH(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .I0(a_i0), .I1(a_i1), .I2(a_i2), .I3(a_i3),
        .S0(S0), .S1(S1), .en(en),
        .Y(a_y), .Y_q(a_yq), .Y_vld(a_vld),
        .sel_oh(a_oh), .sel_chg(a_chg), .chg_cnt(a_cnt)
    );

    mux41_bh #(.WIDTH(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .I0(b_i0), .I1(b_i1), .I2(b_i2), .I3(b_i3),
        .S0(S0), .S1(S1), .en(en),
        .Y(b_y), .Y_q(b_yq), .Y_vld(b_vld),
        .sel_oh(b_oh), .sel_chg(b_chg), .chg_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and step past it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] vec;
    logic [1:0] idx;
    logic [1:0] b_exp_cnt;

    initial begin
        n_total = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        S0 = 1'b0; S1 = 1'b0; en = 1'b0;
        a_i0 = 8'h00; a_i1 = 8'h00; a_i2 = 8'h00; a_i3 = 8'h00;
        b_i0 = 1'b0;  b_i1 = 1'b0;  b_i2 = 1'b0;  b_i3 = 1'b0;
        #2;

        // Reset state
        check("rst_a_yq",  32'(a_yq),  32'h0);
        check("rst_a_vld", 32'(a_vld), 32'h0);
        check("rst_a_chg", 32'(a_chg), 32'h0);
        check("rst_a_cnt", 32'(a_cnt), 32'h0);
        check("rst_b_cnt", 32'(b_cnt), 32'h0);

        // Exhaustive combinational sweep on the 1-bit instance
        for (int v = 0; v < 64; v++) begin
            vec  = 6'(v);
            b_i0 = vec[0]; b_i1 = vec[1]; b_i2 = vec[2]; b_i3 = vec[3];
            S0   = vec[4]; S1 = vec[5];
            idx  = vec[5:4];
            #1;
            check("comb_y",  32'(b_y),  32'(vec[idx]));
            check("comb_oh", 32'(b_oh), 32'(4'b0001 << idx));
        end
        // Named example: I2=1 only, select 10
        b_i0 = 1'b0; b_i1 = 1'b0; b_i2 = 1'b1; b_i3 = 1'b0; S1 = 1'b1; S0 = 1'b0;
        #1;
        check("ex_y",  32'(b_y),  32'h1);
        check("ex_oh", 32'(b_oh), 32'h4);

        // Release reset with select 00, then walk 00,01,01,11
        tick();
        S1 = 1'b0; S0 = 1'b0;
        rst_n = 1'b1;
        tick();
        check("cd0_chg", 32'(a_chg), 32'h0);
        check("cd0_cnt", 32'(a_cnt), 32'h0);
        S0 = 1'b1;
        tick();
        check("cd1_chg", 32'(a_chg), 32'h1);
        check("cd1_cnt", 32'(a_cnt), 32'h1);
        tick();
        check("cd2_chg", 32'(a_chg), 32'h0);
        check("cd2_cnt", 32'(a_cnt), 32'h1);
        S1 = 1'b1;
        tick();
        check("cd3_chg", 32'(a_chg), 32'h1);
        check("cd3_cnt", 32'(a_cnt), 32'h2);
        check("cd3_bcnt", 32'(b_cnt), 32'h2);
        check("cd3_vld", 32'(a_vld), 32'h0);

        // Registered capture with simultaneous select change
        a_i1 = 8'hA5; S1 = 1'b0; S0 = 1'b1; en = 1'b1;
        tick();
        check("cap_yq",  32'(a_yq),  32'hA5);
        check("cap_vld", 32'(a_vld), 32'h1);
        check("cap_chg", 32'(a_chg), 32'h1);
        check("cap_cnt", 32'(a_cnt), 32'h3);
        en = 1'b0; a_i1 = 8'h3C;
        #1;
        check("cap_ycomb", 32'(a_y), 32'h3C);
        tick();
        check("hold1_yq",  32'(a_yq),  32'hA5);
        check("hold1_vld", 32'(a_vld), 32'h0);
        check("hold1_chg", 32'(a_chg), 32'h0);
        tick();
        check("hold2_yq",  32'(a_yq),  32'hA5);
        check("hold2_vld", 32'(a_vld), 32'h0);

        // Build Y_q=FF, chg_cnt=5
        a_i2 = 8'hFF; S1 = 1'b1; S0 = 1'b0; en = 1'b1;
        tick();
        check("ff_yq",  32'(a_yq),  32'hFF);
        check("ff_cnt", 32'(a_cnt), 32'h4);
        S0 = 1'b1; en = 1'b0;
        tick();
        check("pre_rst_yq",  32'(a_yq),  32'hFF);
        check("pre_rst_cnt", 32'(a_cnt), 32'h5);
        check("pre_rst_bcnt", 32'(b_cnt), 32'h3);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_yq",  32'(a_yq),  32'h0);
        check("arst_vld", 32'(a_vld), 32'h0);
        check("arst_chg", 32'(a_chg), 32'h0);
        check("arst_cnt", 32'(a_cnt), 32'h0);
        check("arst_bcnt", 32'(b_cnt), 32'h0);
        a_i3 = 8'h5A;
        #1;
        check("arst_y",  32'(a_y),  32'h5A);
        check("arst_oh", 32'(a_oh), 32'h8);
        tick();
        check("arst_hold_cnt", 32'(a_cnt), 32'h0);

        // Release with select 11: first edge counts a change
        rst_n = 1'b1;
        tick();
        check("rel_chg",  32'(a_chg), 32'h1);
        check("rel_cnt",  32'(a_cnt), 32'h1);
        check("rel_bcnt", 32'(b_cnt), 32'h1);
        check("rel_yq",   32'(a_yq),  32'h0);

        // Toggle-and-return between edges is invisible
        S0 = 1'b0;
        #2;
        S0 = 1'b1;
        tick();
        check("glitch_chg", 32'(a_chg), 32'h0);
        check("glitch_cnt", 32'(a_cnt), 32'h1);

        // Saturation of the 2-bit counter: toggle S0 for six edges
        b_exp_cnt = 2'd1;
        for (int k = 0; k < 6; k++) begin
            S0 = ~S0;
            tick();
            if (b_exp_cnt != 2'd3) b_exp_cnt = b_exp_cnt + 2'd1;
            check("sat_bcnt", 32'(b_cnt), 32'(b_exp_cnt));
            check("sat_bchg", 32'(b_chg), 32'h1);
        end
        check("sat_acnt", 32'(a_cnt), 32'h7);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule

// File: doc/mux41_bh.md
# mux41_bh

Four-input, one-output selector with a 2-bit select (S1 MSB, S0 LSB). It provides a zero-latency combinational output, plus a registered copy with a valid flag. It also provides one-hot select decode and select-change tracking. It sits in datapath steering logic wherever one of four equal-width sources must be routed to a single consumer, with an optional registered boundary.

## Interface
Parameters:
- WIDTH, default 1, bit width of each data input and of the outputs.
- CNT_W, default 8, width of the saturating select-change counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- I0  input  WIDTH  data source selected when {S1,S0}=00.
- I1  input  WIDTH  data source selected when {S1,S0}=01.
- I2  input  WIDTH  data source selected when {S1,S0}=10.
- I3  input  WIDTH  data source selected when {S1,S0}=11.
- S0  input  1  select LSB.
- S1  input  1  select MSB.
- en  input  1  capture enable for the registered output.
- Y  output  WIDTH  combinational selected data.
- Y_q  output  WIDTH  registered selected data.
- Y_vld  output  1  Y_q was loaded on the last edge.
- sel_oh  output  4  combinational one-hot decode of {S1,S0}; bit n is high when In is selected.
- sel_chg  output  1  registered one-cycle pulse on a select change.
- chg_cnt  output  CNT_W  saturating count of select changes.

## Operation
- Y = I0/I1/I2/I3 for {S1,S0} = 00/01/10/11.
  - Purely combinational.
  - Responds to any data or select change with no clock involvement.
  - Depends on neither clk nor rst_n.
- sel_oh = 4'b0001 << {S1,S0}; exactly one bit is high at all times.
- Registered path, on each rising clk edge:
  - en=1: Y_q <= Y and Y_vld <= 1.
  - en=0: Y_q holds and Y_vld <= 0.
- Select tracking:
  - An internal sel_prev register captures {S1,S0} every cycle, independent of en.
  - sel_chg <= ({S1,S0} != sel_prev).
  - When the select changes, chg_cnt <= chg_cnt + 1.
  - chg_cnt saturates at 2^CNT_W-1 and does not wrap.
- Arithmetic: chg_cnt is unsigned. No other arithmetic.
- Select inputs carrying X or Z need no defined behaviour. Synthesis must produce a full case with no latches.

## Timing
- Y and sel_oh have 0-cycle latency and are combinational from every input.
- Y_q, Y_vld, sel_chg and chg_cnt have 1-cycle latency from the sampled inputs.
- Reset values while rst_n=0, applied immediately (asynchronous):
  - Y_q=0, Y_vld=0, sel_chg=0, chg_cnt=0, sel_prev=2'b00.
- Reset release: the first edge compares against sel_prev=00. If the select is non-zero at that edge, sel_chg pulses and chg_cnt becomes 1.
- Reset asserted mid-operation:
  - All registered outputs clear at once.
  - Y and sel_oh keep following the inputs.
- A select change and en=1 on the same edge: Y_q captures the data for the new select, and sel_chg pulses on that same edge.
- A select that toggles and returns between edges is not counted. Only edge-sampled values are compared.

## Structure
- Shared package mux41_pkg holds:
  - A 2-bit sel_t typedef.
  - Constants SEL_I0=2'b00, SEL_I1=2'b01, SEL_I2=2'b10, SEL_I3=2'b11.
  - A function returning the one-hot decode of a sel_t.
- One natural sub-module: mux41_comb, the combinational WIDTH-wide 4:1 selector producing Y.
- The top level adds the registers, the change detector and the counter.

## Test plan
- Exhaustive combinational check: WIDTH=1, sweep all 64 combinations of I0..I3, S1, S0 -> Y equals the input indexed by {S1,S0}, e.g. I2=1, others 0, S1=1, S0=0 -> Y=1. sel_oh=0100 in that case.
- Registered capture: WIDTH=8, I1=8'hA5, {S1,S0}=01, en=1 for one edge, then en=0 with I1=8'h3C -> Y_q=8'hA5 and Y_vld=1 for exactly one cycle, then Y_q holds 8'hA5 and Y_vld=0.
- Change detection: select sequence 00,01,01,11 on successive edges after reset -> sel_chg = 0,1,0,1 and chg_cnt ends at 2.
- Saturation: CNT_W=2, toggle S0 every cycle for 6 edges -> chg_cnt reaches 3 and stays 3.
- Asynchronous reset: with Y_q=8'hFF and chg_cnt=5, drop rst_n between edges -> Y_q, Y_vld, sel_chg and chg_cnt are 0 immediately, while Y still tracks the inputs.
- Reset release with select 11: first edge -> sel_chg=1 and chg_cnt=1.
